// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with mid-bit sampling, a single-entry
//             valid/ready output holding register, and frame-error and
//             overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // The bit timer must be able to hold CLKS_PER_BIT-1.
    localparam int c_TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TMR_W-1:0] c_BIT_END  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_HALF_END = c_TMR_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [c_TMR_W-1:0]   r_timer;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_sample;
    logic                 w_deliver;
    logic                 w_bad_stop;

    // Two-flop synchronizer; flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-cycle strobes for sampling and stop-bit outcome.
    always_comb begin
        w_next     = r_state;
        w_sample   = 1'b0;
        w_deliver  = 1'b0;
        w_bad_stop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                // Re-check the line at the middle of the start bit; a high
                // level here means the falling edge was only a glitch.
                if (r_timer == c_HALF_END) begin
                    w_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_timer == c_BIT_END) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_timer == c_BIT_END) begin
                    if (r_rx_s) begin
                        w_deliver = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_bad_stop = 1'b1;
                        w_next     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Hold off until the line returns high so a break does not
                // look like a new start bit.
                if (r_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit timer: cleared on every state change and at each data-bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if ((w_next != r_state) || w_sample) begin
            r_timer <= '0;
        end else if ((r_state == S_START) || (r_state == S_DATA) ||
                     (r_state == S_STOP)) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    // Bit index counts samples 0..7 and saturates; cleared outside DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
        end else if (r_state != S_DATA) begin
            r_bit_idx <= 3'd0;
        end else if (w_sample && (r_bit_idx != 3'd7)) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Shift register: each sample enters at the MSB so bit 0 ends up LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 8'h00;
        end else if (w_sample) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    // Output holding register with overrun detection and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (r_rx_valid && !rx_ready) begin
                    // Pending byte not consumed: drop the new one.
                    r_overrun <= 1'b1;
                end else begin
                    // Either empty or consumed this cycle: take the new byte.
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx at CLKS_PER_BIT = 16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    // Event counters maintained by the monitor; scenarios compare deltas.
    int         n_valid_cyc = 0;
    int         n_ferr      = 0;
    int         n_ovr       = 0;
    logic [7:0] last_data   = 8'h00;
    int         s_valid, s_ferr, s_ovr;

    // rx_valid as seen at each falling edge of the most recent frame.
    logic v_hist [0:159];

    uart_rx #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid_cyc = n_valid_cyc + 1;
            last_data   = rx_data;
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (overrun)   n_ovr  = n_ovr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic snap();
        s_valid = n_valid_cyc;
        s_ferr  = n_ferr;
        s_ovr   = n_ovr;
    endtask

    // Drive one 8N1 frame, one bit per 16 cycles, changes at falling edges.
    // rdy_pulse_at forces rx_ready high for one chosen cycle; abort_at
    // asserts reset at that cycle and leaves the frame unfinished.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic rdy, input int rdy_pulse_at,
                              input int abort_at);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int c = 0; c < 10 * c_CPB; c++) begin
            @(negedge clk);
            v_hist[c] = rx_valid;
            if (c == abort_at) begin
                rst_n = 1'b0;
                rx    = 1'b1;
                return;
            end
            rx       = bits[c / c_CPB];
            rx_ready = (c == rdy_pulse_at) ? 1'b1 : rdy;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_rx_data",   32'(rx_data),   32'h00);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun",   32'(overrun),   32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55 with rx_ready held high: start seen at cycle 2, mid-start
        // check at 10, bit samples at 26+16k, stop sample at 154, so
        // rx_valid is visible from falling edge 155 for exactly one cycle.
        snap();
        send_frame(8'h55, 1'b1, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check("b55_valid_before", 32'(v_hist[154]), 32'd0);
        check("b55_valid_at",     32'(v_hist[155]), 32'd1);
        check("b55_valid_after",  32'(v_hist[156]), 32'd0);
        check("b55_data",         32'(last_data), 32'h55);
        check("b55_valid_cycles", 32'(n_valid_cyc - s_valid), 32'd1);
        check("b55_no_ferr",      32'(n_ferr - s_ferr), 32'd0);
        check("b55_busy_low",     32'(busy), 32'd0);

        // Five-cycle low glitch on an idle line
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_in_start", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_low",  32'(busy), 32'd0);
        check("glitch_no_valid",  32'(n_valid_cyc - s_valid), 32'd0);
        check("glitch_no_ferr",   32'(n_ferr - s_ferr), 32'd0);

        // 0xA3 with a low stop bit, line held low 40 more cycles
        snap();
        send_frame(8'hA3, 1'b0, 1'b1, -1, -1);
        repeat (40) @(negedge clk);
        check("ferr_busy_held",  32'(busy), 32'd1);
        check("ferr_one_pulse",  32'(n_ferr - s_ferr), 32'd1);
        check("ferr_no_valid",   32'(n_valid_cyc - s_valid), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("ferr_busy_release", 32'(busy), 32'd0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check("after_ferr_data",  32'(last_data), 32'h3C);
        check("after_ferr_valid", 32'(n_valid_cyc - s_valid), 32'd1);

        // 0x11 then 0x22 back to back with no consumer
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1, -1);
        repeat (4) @(negedge clk);
        check("ovr_data_kept",   32'(rx_data), 32'h11);
        check("ovr_valid_held",  32'(rx_valid), 32'd1);
        check("ovr_one_pulse",   32'(n_ovr - s_ovr), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("ovr_consume_clears", 32'(rx_valid), 32'd0);

        // 0x22 delivered in the same cycle 0x11 is consumed (cycle 154)
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        snap();
        send_frame(8'h22, 1'b1, 1'b0, 154, -1);
        repeat (2) @(negedge clk);
        check("same_cyc_data",   32'(rx_data), 32'h22);
        check("same_cyc_valid",  32'(rx_valid), 32'd1);
        check("same_cyc_no_ovr", 32'(n_ovr - s_ovr), 32'd0);

        // Reset during data bit 4 of 0xF0 (0x22 still pending beforehand)
        send_frame(8'hF0, 1'b1, 1'b0, -1, 5 * c_CPB + 5);
        #1;
        check("midrst_rx_data",   32'(rx_data),   32'h00);
        check("midrst_rx_valid",  32'(rx_valid),  32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overrun",   32'(overrun),   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (20) @(negedge clk);
        check("postrst_idle_busy", 32'(busy), 32'd0);
        check("postrst_no_valid",  32'(n_valid_cyc - s_valid), 32'd0);
        check("postrst_no_ferr",   32'(n_ferr - s_ferr), 32'd0);
        rx_ready = 1'b1;
        snap();
        send_frame(8'h0F, 1'b1, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check("postrst_data",  32'(last_data), 32'h0F);
        check("postrst_valid", 32'(n_valid_cyc - s_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
